// File: rtl/seq_alu.sv
// seq_alu: clocked WIDTH-bit ALU with iterative signed radix-2 mul/div and a start/busy/done handshake.
// Define SEQ_ALU_FLAGS_EN to add registered zero/negative flags (flag_z, flag_n).
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               start,
   input  logic [4:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z,
`ifdef SEQ_ALU_FLAGS_EN
   output logic               flag_z,
   output logic               flag_n,
`endif
   output logic               err
);
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                          OP_OR = 5'b00110, OP_SHR = 5'b00111, OP_SHRA = 5'b01000,
                          OP_SHL = 5'b01001, OP_ROR = 5'b01010, OP_ROL = 5'b01011,
                          OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001,
                          OP_NOT = 5'b10010;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t r_state, w_state_nxt;
   logic [2*WIDTH-1:0] r_z, w_z_nxt, w_p, w_pfin, w_dfin;
   logic [WIDTH-1:0]   r_hi, r_lo, r_m, w_res, w_aa, w_ab, w_mhi, w_mlo, w_dhi, w_dlo;
   logic [WIDTH:0]     w_sum, w_sh, w_dif;
   logic [SHW-1:0]     r_cnt, w_amt, w_namt;
   logic               r_err, r_mul, r_sq, r_sr, w_err_nxt, w_legal, w_iter, w_load, w_go, w_ge;
   assign busy   = (r_state == RUN);
   assign done   = (r_state == DONE);
   assign z      = r_z;
   assign err    = r_err;
   assign w_amt  = b[SHW-1:0];
   assign w_namt = -w_amt;
   assign w_aa   = a[WIDTH-1] ? -a : a;
   assign w_ab   = b[WIDTH-1] ? -b : b;
   assign w_iter = (op == OP_MUL) || (op == OP_DIV && b != '0);
   // mul: shift-add on magnitudes, multiplier in r_lo, product grows into r_hi
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
   assign w_mhi  = w_sum[WIDTH:1];
   assign w_mlo  = {w_sum[0], r_lo[WIDTH-1:1]};
   assign w_p    = {w_mhi, w_mlo};
   assign w_pfin = r_sq ? -w_p : w_p;
   // div: restoring division on magnitudes, remainder in r_hi, quotient shifts into r_lo
   assign w_sh   = {r_hi, r_lo[WIDTH-1]};
   assign w_dif  = w_sh - {1'b0, r_m};
   assign w_ge   = ~w_dif[WIDTH];
   assign w_dhi  = w_ge ? w_dif[WIDTH-1:0] : w_sh[WIDTH-1:0];
   assign w_dlo  = {r_lo[WIDTH-2:0], w_ge};
   assign w_dfin = {r_sr ? -w_dhi : w_dhi, r_sq ? -w_dlo : w_dlo};
   always_comb begin
      w_res   = '0;
      w_legal = 1'b1;
      case (op)
         OP_ADD:  w_res = a + b;
         OP_SUB:  w_res = a - b;
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_SHR:  w_res = a >> w_amt;
         OP_SHRA: w_res = $signed(a) >>> w_amt;
         OP_SHL:  w_res = a << w_amt;
         OP_ROR:  w_res = (a >> w_amt) | (a << w_namt);
         OP_ROL:  w_res = (a << w_amt) | (a >> w_namt);
         OP_NEG:  w_res = (~a) + 1'b1;
         OP_NOT:  w_res = ~a;
         default: w_legal = 1'b0;
      endcase
   end
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_go        = 1'b0;
      w_z_nxt     = r_z;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: if (start) begin
            if (w_iter) begin
               w_go        = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_load      = 1'b1;
               w_state_nxt = DONE;
               w_z_nxt     = (op == OP_DIV) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_res};
               w_err_nxt   = ~w_legal;
            end
         end
         RUN: if (r_cnt == '0) begin
            w_load      = 1'b1;
            w_state_nxt = DONE;
            w_z_nxt     = r_mul ? w_pfin : w_dfin;
            w_err_nxt   = 1'b0;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) begin
         r_z   <= '0;
         r_err <= 1'b0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_m   <= '0;
         r_cnt <= '0;
         r_mul <= 1'b0;
         r_sq  <= 1'b0;
         r_sr  <= 1'b0;
      end else begin
         if (w_load) begin
            r_z   <= w_z_nxt;
            r_err <= w_err_nxt;
         end
         if (w_go) begin
            r_mul <= (op == OP_MUL);
            r_hi  <= '0;
            r_lo  <= (op == OP_MUL) ? w_ab : w_aa;
            r_m   <= (op == OP_MUL) ? w_aa : w_ab;
            r_sq  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sr  <= a[WIDTH-1];
            r_cnt <= SHW'(WIDTH - 1);
         end else if (r_state == RUN) begin
            r_hi  <= r_mul ? w_mhi : w_dhi;
            r_lo  <= r_mul ? w_mlo : w_dlo;
            r_cnt <= r_cnt - 1'b1;
         end
      end
`ifdef SEQ_ALU_FLAGS_EN
   logic r_fz, r_fn, w_fmul;
   assign w_fmul = (r_state == RUN) && r_mul;
   assign flag_z = r_fz;
   assign flag_n = r_fn;
   always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) begin
         r_fz <= 1'b0;
         r_fn <= 1'b0;
      end else if (w_load) begin
         r_fz <= w_fmul ? (w_z_nxt == '0) : (w_z_nxt[WIDTH-1:0] == '0);
         r_fn <= w_fmul ? w_z_nxt[2*WIDTH-1] : w_z_nxt[WIDTH-1];
      end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;
   logic        clock = 1'b0, clear_n = 1'b0, start = 1'b0;
   logic [4:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, err;
   logic [63:0] z;
   int          n_chk = 0, n_fail = 0;
`ifdef SEQ_ALU_FLAGS_EN
   logic flag_z, flag_n;
`endif
   seq_alu #(.WIDTH(32)) dut (
      .clock(clock), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .z(z),
`ifdef SEQ_ALU_FLAGS_EN
      .flag_z(flag_z), .flag_n(flag_n),
`endif
      .err(err)
   );
   always #5 clock = ~clock;
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [63:0] ez, output logic ee, output int el);
      int sx, sy, sh;
      longint q, r;
      logic [31:0] t;
      sx = x; sy = y; sh = int'(y[4:0]); t = x;
      ez = '0; ee = 1'b0; el = 1;
      case (o)
         5'b00011: ez[31:0] = x + y;
         5'b00100: ez[31:0] = x - y;
         5'b00101: ez[31:0] = x & y;
         5'b00110: ez[31:0] = x | y;
         5'b00111: ez[31:0] = x >> sh;
         5'b01000: ez[31:0] = 32'(sx >>> sh);
         5'b01001: ez[31:0] = x << sh;
         5'b01010: begin repeat (sh) t = {t[0], t[31:1]}; ez[31:0] = t; end
         5'b01011: begin repeat (sh) t = {t[30:0], t[31]}; ez[31:0] = t; end
         5'b01111: begin el = 33; ez = longint'(sx) * longint'(sy); end
         5'b10000: if (y == 0) begin
               ez = {x, 32'hFFFFFFFF}; ee = 1'b1;
            end else begin
               el = 33;
               q = longint'(sx) / longint'(sy);
               r = longint'(sx) % longint'(sy);
               ez = {r[31:0], q[31:0]};
            end
         5'b10001: ez[31:0] = -x;
         5'b10010: ez[31:0] = ~x;
         default: ee = 1'b1;
      endcase
   endfunction
   task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
      logic [63:0] ez, zh;
      logic ee;
      int el, lat, nb;
      bit seen;
      model(o, x, y, ez, ee, el);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
      lat = 1; nb = 0; seen = 1'b0;
      while (lat <= 40 && !seen) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) nb++;
            if (lat == poke) begin
               start = 1'b1; op = 5'b10000; a = $urandom; b = $urandom;
            end else start = 1'b0;
            @(negedge clock);
            lat++;
         end
      end
      start = 1'b0;
      chk($sformatf("lat op=%b", o), 64'(lat), 64'(el));
      if (seen) begin
         chk($sformatf("z op=%b a=%h b=%h", o, x, y), z, ez);
         chk($sformatf("err op=%b", o), 64'(err), 64'(ee));
         chk($sformatf("busy_cycles op=%b", o), 64'(nb), 64'(el - 1));
`ifdef SEQ_ALU_FLAGS_EN
         chk("flag_z", 64'(flag_z), 64'((o == 5'b01111) ? (ez == '0) : (ez[31:0] == '0)));
         chk("flag_n", 64'(flag_n), 64'((o == 5'b01111) ? ez[63] : ez[31]));
`endif
         zh = z;
         @(negedge clock);
         chk("done_pulse", 64'(done), 64'(0));
         chk("z_hold", z, zh);
      end
   endtask
   typedef struct {logic [4:0] o; logic [31:0] x; logic [31:0] y;} vec_t;
   vec_t dir[] = '{
      '{5'b00011, 32'hFFFFFFFF, 32'h1},  '{5'b00100, 32'd5, 32'd7},
      '{5'b01000, 32'h80000001, 32'd4},  '{5'b01010, 32'h80000001, 32'd36},
      '{5'b01011, 32'h80000001, 32'd0},  '{5'b00111, 32'h80000001, 32'd31},
      '{5'b01001, 32'h80000001, 32'd3},  '{5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0},
      '{5'b00110, 32'hF0F0F0F0, 32'h0FF00FF0}, '{5'b10010, 32'h12345678, 32'h0},
      '{5'b01111, 32'h80000000, 32'h80000000}, '{5'b10000, 32'hFFFFFFF9, 32'd2},
      '{5'b10000, 32'h80000000, 32'hFFFFFFFF}, '{5'b10000, 32'd9, 32'd0},
      '{5'b11111, 32'h1234, 32'h5678},   '{5'b00100, 32'd4, 32'd4},
      '{5'b10001, 32'd1, 32'd0}
   };
   logic [4:0] ops[14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                           5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11100};
   initial begin
      int nd;
      logic [4:0] o;
      logic [31:0] x, y;
      repeat (2) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_z", z, 64'(0));
      clear_n = 1'b1;
      foreach (dir[i]) run_op(dir[i].o, dir[i].x, dir[i].y, 0);
      run_op(5'b01111, 32'hFFFFFFFD, 32'd7, 5);
      chk("mul_plan", z, 64'hFFFFFFFFFFFFFFEB);
      for (int i = 0; i < 40; i++) begin
         o = ops[$urandom_range(13)];
         x = $urandom;
         y = $urandom;
         if (i % 4 == 0) y = y >> $urandom_range(31);
         if (o == 5'b01111 && y == 0) y = 32'd1;
         if (o == 5'b10000 && i % 10 == 0) y = 0;
         run_op(o, x, y, (i % 3 == 0) ? int'($urandom_range(1, 20)) : 0);
      end
      run_op(5'b10000, 32'd100, 32'd7, 0);
      @(negedge clock);
      start = 1'b1; op = 5'b10000; a = 32'hFFFF0000; b = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      chk("busy_mid_div", 64'(busy), 64'(1));
      #2 clear_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_z", z, 64'(0));
      chk("arst_err", 64'(err), 64'(0));
      @(negedge clock);
      clear_n = 1'b1;
      nd = 0;
      repeat (45) begin
         @(negedge clock);
         if (done) nd++;
      end
      chk("no_done_after_rst", 64'(nd), 64'(0));
      run_op(5'b00011, 32'd40, 32'd2, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
